div_unit: RTL and testbench

//  Multi-cycle iterative divider for the RV32M div/divu/rem/remu instructions.

---
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle; divide-by-zero and signed overflow are
// resolved directly from IDLE without iterating.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; operands, op and signs latched on accept
// CALC  | one restoring shift/subtract step per cycle, DATA_WIDTH steps
// FIXUP | apply result signs, select quotient or remainder
// DONE  | result presented with a one-cycle valid_o pulse
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  dbz_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]         CNT_INIT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]         CNT_LAST = CW'(1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONES     = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic                  rem_sel_q;
  logic                  quo_neg_q;
  logic                  rem_neg_q;
  logic [DATA_WIDTH-1:0] stage_q;
  logic                  stage_dbz_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  dbz_q;

  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  ovf_case;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  // Operand conditioning and one restoring step of the datapath.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & a_i[DATA_WIDTH-1];
    b_neg     = is_signed & b_i[DATA_WIDTH-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
    ovf_case  = is_signed & (a_i == MIN_VAL) & (b_i == ONES);
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = shifted - {1'b0, div_q};
    quo_fix   = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Control FSM and working registers; flush_i overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      rem_sel_q   <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      stage_q     <= '0;
      stage_dbz_q <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_sel_q <= op_i[1];
            if (b_i == '0) begin
              stage_q     <= op_i[1] ? a_i : ONES;
              stage_dbz_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (ovf_case) begin
              stage_q     <= op_i[1] ? '0 : MIN_VAL;
              stage_dbz_q <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              quo_q       <= a_mag;
              div_q       <= b_mag;
              rem_q       <= '0;
              cnt_q       <= CNT_INIT;
              quo_neg_q   <= a_neg ^ b_neg;
              rem_neg_q   <= a_neg;
              stage_dbz_q <= 1'b0;
              state_q     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!trial[DATA_WIDTH]) begin
            rem_q <= trial[DATA_WIDTH-1:0];
          end else begin
            rem_q <= shifted[DATA_WIDTH-1:0];
          end
          quo_q <= {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          stage_q <= rem_sel_q ? rem_fix : quo_fix;
          state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= stage_q;
          dbz_q    <= stage_dbz_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The new result shows during DONE but only sticks if the op is not
  // killed in that same cycle, so a flushed op never alters result_o.
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    valid_o  = (state_q == S_DONE) & ~flush_i;
    result_o = valid_o ? stage_q : result_q;
    dbz_o    = valid_o ? stage_dbz_q : dbz_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, flush and
// reset behaviour, then a random sweep scored against a reference model.
module tb_div_unit;

  localparam int W      = 32;
  localparam int N_RAND = 1200;
  localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;
  localparam logic [W-1:0] ONES    = 32'hFFFF_FFFF;

  logic         clk_i   = 1'b0;
  logic         rst_ni  = 1'b0;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   op_i    = 2'b00;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic         dbz_o;

  int n_chk     = 0;
  int n_fail    = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .dbz_o    (dbz_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (valid_o) valid_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sa    = a;
    sbv   = b;
    e.dbz = 1'b0;
    e.lat = W + 2;
    if (b == '0) begin
      q = ONES; r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (!op[0] && a == MIN_VAL && b == ONES) begin
      q = MIN_VAL; r = '0; e.lat = 1;
    end else if (!op[0]) begin
      q = sa / sbv; r = sa % sbv;
    end else begin
      q = a / b; r = a % b;
    end
    e.res = op[1] ? r : q;
    return e;
  endfunction

  // Drives one op, waits for valid_o within a bound and scores it. With
  // noise set, extra start_i pulses are thrown in while the unit is busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit noise);
    exp_t e;
    int lat;
    sb.push_back(model(op, a, b));
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
      if (noise) start_i = (lat % 5 == 2);
    end
    start_i = 1'b0;
    e = sb.pop_front();
    if (!valid_o) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, W'(lat), W'(e.lat));
      chk({tag, "_res"}, result_o, e.res);
      chk({tag, "_dbz"}, W'(dbz_o), W'(e.dbz));
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [W-1:0] prev;
    int vc0;
    int lat;
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1;
    chk("rst_busy", W'(busy_o), 32'd0);
    chk("rst_valid", W'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_dbz", W'(dbz_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 1'b0);
    run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 1'b0);
    run_op("rem_7_m2", 2'b10, 32'd7, -32'sd2, 1'b0);
    run_op("div_dbz", 2'b00, 32'h1234_5678, 32'd0, 1'b0);
    run_op("rem_dbz", 2'b10, 32'h1234_5678, 32'd0, 1'b0);
    run_op("divu_dbz", 2'b01, 32'h0000_0005, 32'd0, 1'b0);
    run_op("div_ovf", 2'b00, MIN_VAL, ONES, 1'b0);
    run_op("rem_ovf", 2'b10, MIN_VAL, ONES, 1'b0);
    run_op("divu_min_ones", 2'b01, MIN_VAL, ONES, 1'b0);
    run_op("div_min_2", 2'b00, MIN_VAL, 32'd2, 1'b0);

    // flush in the middle of CALC
    prev = result_o;
    vc0  = valid_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_busy", W'(busy_o), 32'd0);
    repeat (40) @(posedge clk_i);
    #1;
    chk("flush_no_valid", W'(valid_cnt - vc0), 32'd0);
    chk("flush_result", result_o, prev);

    // start pulses while busy must not add results
    vc0 = valid_cnt;
    run_op("divu_noise", 2'b01, 32'd1000, 32'd10, 1'b1);
    repeat (40) @(posedge clk_i);
    #1;
    chk("noise_valid_cnt", W'(valid_cnt - vc0), 32'd1);
    chk("noise_idle", W'(busy_o), 32'd0);

    // flush landing in the DONE cycle
    prev = result_o;
    vc0  = valid_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd50; b_i = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("done_reached", W'(valid_o), 32'd1);
    flush_i = 1'b1;
    #1;
    chk("done_flush_valid", W'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("done_flush_busy", W'(busy_o), 32'd0);
    chk("done_flush_result", result_o, prev);
    chk("done_flush_cnt", W'(valid_cnt - vc0), 32'd0);

    // start together with flush in IDLE
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("start_flush_busy", W'(busy_o), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd12345; b_i = 32'd67;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", W'(busy_o), 32'd0);
    chk("arst_valid", W'(valid_o), 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_dbz", W'(dbz_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    run_op("divu_ones_1", 2'b01, ONES, 32'd1, 1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = MIN_VAL; rb = ONES; end
        2: rb = W'($urandom_range(1, 15));
        3: ra = W'($urandom_range(0, 100));
        4: rb = ra;
        5: rb = ONES;
        default: ;
      endcase
      run_op("rand", rop, ra, rb, 1'b0);
    end

    chk("sb_empty", W'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
